// File: rtl/ex_mem_pipe_reg_pkg.sv
// ex_mem_pipe_reg_pkg: control bit positions, default payload layout and width helper
package ex_mem_pipe_reg_pkg;
  localparam int MEM_RD_BIT = 1;
  localparam int MEM_WR_BIT = 0;
  localparam int WB_REGWRITE_BIT = 0;
  localparam int WB_MEMTOREG_BIT = 1;
  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic [31:0] alu_out;
    logic [31:0] rt_data;
    logic [4:0]  rd_addr;
  } ex_mem_payload_t;
  function automatic int payload_w(input int data_w, input int rd_w, input int wb_w);
    return wb_w + 2 + 2 * data_w + rd_w;
  endfunction
endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// ex_mem_pipe_reg_if: EX->MEM pipeline bundle; PIPE_PERF_CNT_EN adds counter outputs
interface ex_mem_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int RD_W = 5,
  parameter int WB_W = 2
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [WB_W-1:0]   wb_i;
  logic [1:0]        mem_i;
  logic [DATA_W-1:0] alu_out_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [RD_W-1:0]   rd_addr_i;
  logic              valid_o;
  logic [WB_W-1:0]   wb_o;
  logic [DATA_W-1:0] alu_out_o;
  logic [DATA_W-1:0] rt_data_o;
  logic [RD_W-1:0]   rd_addr_o;
  logic              mem_read_o;
  logic              mem_write_o;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0]       stall_cnt_o;
  logic [15:0]       bubble_cnt_o;
`endif
  modport master (
`ifdef PIPE_PERF_CNT_EN
    input stall_cnt_o, bubble_cnt_o,
`endif
    output stall_i, flush_i, valid_i, wb_i, mem_i, alu_out_i, rt_data_i, rd_addr_i,
    input valid_o, wb_o, alu_out_o, rt_data_o, rd_addr_o, mem_read_o, mem_write_o
  );
  modport slave (
`ifdef PIPE_PERF_CNT_EN
    output stall_cnt_o, bubble_cnt_o,
`endif
    input stall_i, flush_i, valid_i, wb_i, mem_i, alu_out_i, rt_data_i, rd_addr_i,
    output valid_o, wb_o, alu_out_o, rt_data_o, rd_addr_o, mem_read_o, mem_write_o
  );
endinterface

// File: rtl/ex_mem_pipe_reg_cell.sv
// pipe_stage_cell: one valid+control+data register with async reset, stall hold and flush
module pipe_stage_cell #(
  parameter int CW = 4,
  parameter int DW = 69
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          valid_d,
  input  logic [CW-1:0] ctrl_d,
  input  logic [DW-1:0] data_d,
  output logic          valid_q,
  output logic [CW-1:0] ctrl_q,
  output logic [DW-1:0] data_q
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (!stall_i) begin
      valid_q <= valid_d;
      ctrl_q  <= valid_d ? ctrl_d : '0;
      data_q  <= data_d;
    end
endmodule

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: DEPTH-stage EX->MEM register with stall/flush; PIPE_PERF_CNT_EN adds perf counters
module ex_mem_pipe_reg
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W = 5,
  parameter int WB_W = 2,
  parameter int DEPTH = 1
) (
  input logic clk_i,
  input logic rst_i,
  ex_mem_pipe_reg_if.slave bus
);
  localparam int CW = WB_W + 2;
  localparam int DW = payload_w(DATA_W, RD_W, WB_W) - CW;
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("ex_mem_pipe_reg: DEPTH must be 1..4");
  end
  logic [DEPTH:0]  v;
  logic [CW-1:0]   c [DEPTH+1];
  logic [DW-1:0]   d [DEPTH+1];
  assign v[0] = bus.valid_i;
  assign c[0] = {bus.wb_i, bus.mem_i};
  assign d[0] = {bus.alu_out_i, bus.rt_data_i, bus.rd_addr_i};
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_stage_cell #(.CW(CW), .DW(DW)) u_cell (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .stall_i(bus.stall_i),
      .flush_i(bus.flush_i),
      .valid_d(v[k]),
      .ctrl_d (c[k]),
      .data_d (d[k]),
      .valid_q(v[k+1]),
      .ctrl_q (c[k+1]),
      .data_q (d[k+1])
    );
  end
  assign bus.valid_o     = v[DEPTH];
  assign bus.wb_o        = v[DEPTH] ? c[DEPTH][CW-1:2] : '0;
  assign bus.mem_read_o  = v[DEPTH] & c[DEPTH][MEM_RD_BIT];
  assign bus.mem_write_o = v[DEPTH] & c[DEPTH][MEM_WR_BIT];
  assign bus.alu_out_o   = d[DEPTH][DW-1 -: DATA_W];
  assign bus.rt_data_o   = d[DEPTH][RD_W +: DATA_W];
  assign bus.rd_addr_o   = d[DEPTH][RD_W-1:0];
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt, bubble_cnt;
  logic        bubble;
  // stage0 takes a bubble on flush, or on a non-stalled capture of an empty slot
  assign bubble = bus.flush_i | (~bus.stall_i & ~bus.valid_i);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (bus.stall_i && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (bubble && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
  assign bus.stall_cnt_o  = stall_cnt;
  assign bus.bubble_cnt_o = bubble_cnt;
`endif
endmodule
